ipf_feeder: RTL and testbench

//  Transmit side of the IPF input interface. Fetches weight and input-row words from a
//  1-cycle-latency SRAM and streams them into IPF on w_data/w_valid and i_data/i_valid.

---
 rtl/ipf_pkg.sv | 31 +++
 rtl/ipf_feeder_if.sv | 25 ++
 rtl/ipf_rd_pipe.sv | 42 ++++
 rtl/ipf_feeder.sv | 174 +++++++++++++++++
 tb/tb_ipf_feeder.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ipf_pkg.sv
// Shared encodings and sizing for the IPF feeder: IPF ctrl codes, FSM states,
// read-word tags and the per-pass load geometry.
package ipf_pkg;

  typedef enum logic [1:0] {
    CTRL_END   = 2'd0,
    CTRL_START = 2'd1,
    CTRL_HOLD  = 2'd2
  } ctrl_e;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_W, S_LOAD_I, S_DRAIN, S_ARM,
    S_START, S_RUN, S_HLD, S_FIN, S_DONE
  } state_e;

  typedef enum logic {
    TAG_W = 1'b0,
    TAG_I = 1'b1
  } tag_e;

  localparam int IPF_ROWS    = 8;
  localparam int IPF_RUN_CYC = 32;
  // 4x 3x3 kernels = 36 bytes per pass: 40 B on even passes, 32 B on odd.
  localparam int IPF_NW_EVEN = 5;
  localparam int IPF_NW_ODD  = 4;

  function automatic int nw_words(input logic odd_pass);
    return odd_pass ? IPF_NW_ODD : IPF_NW_EVEN;
  endfunction

endpackage

// File: rtl/ipf_feeder_if.sv
// SRAM read port plus the IPF weight/row stream and result strobe.
interface ipf_feeder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        ctrl;
  logic [DATA_W-1:0] w_data;
  logic              w_valid;
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              res_valid;

  modport master (
    output rd_en, rd_addr, ctrl, w_data, w_valid, i_data, i_valid,
    input  rd_data, res_valid
  );

  modport slave (
    input  rd_en, rd_addr, ctrl, w_data, w_valid, i_data, i_valid,
    output rd_data, res_valid
  );
endinterface

// File: rtl/ipf_rd_pipe.sv
// Tracks reads through the 1-cycle SRAM and lands each word, registered, on the
// weight or row port according to the tag that travelled with it.
module ipf_rd_pipe
  import ipf_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  tag_e              rd_tag,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] w_data,
  output logic              w_valid,
  output logic [DATA_W-1:0] i_data,
  output logic              i_valid
);

  // [1]: read in flight (data on rd_data), [2]: word presented to IPF
  logic [2:1] vld_pipe;
  logic [2:1] tag_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      w_data   <= '0;
      i_data   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], rd_en};
      tag_pipe <= {tag_pipe[1], rd_tag == TAG_I};
      if (vld_pipe[1]) begin
        if (tag_pipe[1]) i_data <= rd_data;
        else             w_data <= rd_data;
      end
    end
  end

  assign w_valid = vld_pipe[2] & ~tag_pipe[2];
  assign i_valid = vld_pipe[2] &  tag_pipe[2];

endmodule

// File: rtl/ipf_feeder.sv
// IPF feeder: per pass, loads weights and input rows from SRAM into IPF, then
// sequences START/RUN/HOLD, checking the res_valid beat count; END after the last pass.
module ipf_feeder
  import ipf_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 64,
  parameter int ROWS    = IPF_ROWS,
  parameter int RUN_CYC = IPF_RUN_CYC,
  parameter int PASS_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_i_base,
  input  logic [PASS_W-1:0] cfg_npass,
  input  logic              sink_ready,
  ipf_feeder_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2((RUN_CYC > ROWS ? RUN_CYC : ROWS) + 1);
  localparam logic [CNT_W-1:0] ROWS_LAST  = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYC - 1);
  localparam logic [CNT_W-1:0] RUN_FULL   = CNT_W'(RUN_CYC);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  res_q, res_d;
  logic [PASS_W-1:0] pass_q, pass_d, npass_q, npass_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d, iptr_q, iptr_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  nw_last;
  logic [PASS_W-1:0] pass_nx;
  logic              rd_en_c;
  logic [ADDR_W-1:0] rd_addr_c;
  tag_e              rd_tag_c;
  ctrl_e             ctrl_c;

  assign nw_last = CNT_W'(nw_words(pass_q[0]) - 1);
  assign pass_nx = pass_q + PASS_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      pass_q  <= '0;
      npass_q <= '0;
      wptr_q  <= '0;
      iptr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      pass_q  <= pass_d;
      npass_q <= npass_d;
      wptr_q  <= wptr_d;
      iptr_q  <= iptr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    pass_d    = pass_q;
    npass_d   = npass_q;
    wptr_d    = wptr_q;
    iptr_d    = iptr_q;
    err_d     = err_q;
    rd_en_c   = 1'b0;
    rd_addr_c = '0;
    rd_tag_c  = TAG_W;
    ctrl_c    = CTRL_HOLD;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (cfg_start) begin
          npass_d = cfg_npass;
          wptr_d  = cfg_w_base;
          iptr_d  = cfg_i_base;
          pass_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = (cfg_npass == '0) ? S_FIN : S_LOAD_W;
        end
      end
      // weight pointer runs on across passes; row pointer advances ROWS per pass
      S_LOAD_W: begin
        rd_en_c   = 1'b1;
        rd_addr_c = wptr_q;
        wptr_d    = wptr_q + ADDR_W'(1);
        if (cnt_q == nw_last) begin
          cnt_d   = '0;
          state_d = S_LOAD_I;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_LOAD_I: begin
        rd_en_c   = 1'b1;
        rd_tag_c  = TAG_I;
        rd_addr_c = iptr_q;
        iptr_d    = iptr_q + ADDR_W'(1);
        if (cnt_q == ROWS_LAST) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = S_ARM;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_ARM: if (sink_ready) state_d = S_START;
      S_START: begin
        ctrl_c  = CTRL_START;
        res_d   = '0;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      // IPF keeps computing while START is held
      S_RUN: begin
        ctrl_c = CTRL_START;
        if (bus.res_valid) res_d = res_q + CNT_W'(1);
        if (cnt_q == RUN_LAST) begin
          cnt_d   = '0;
          state_d = S_HLD;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_HLD: begin
        if (res_q != RUN_FULL) err_d = 1'b1;
        pass_d  = pass_nx;
        state_d = (pass_nx == npass_q) ? S_FIN : S_LOAD_W;
      end
      S_FIN: begin
        ctrl_c  = CTRL_END;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rd_en   = rd_en_c;
  assign bus.rd_addr = rd_addr_c;
  assign bus.ctrl    = ctrl_c;
  assign err         = err_q;

  ipf_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en_c),
    .rd_tag  (rd_tag_c),
    .rd_data (bus.rd_data),
    .w_data  (bus.w_data),
    .w_valid (bus.w_valid),
    .i_data  (bus.i_data),
    .i_valid (bus.i_valid)
  );

endmodule

// File: tb/tb_ipf_feeder.sv
// Bench for ipf_feeder: SRAM and IPF models, a per-job timeline model built from
// the pass schedule, a vector table, random jobs and a mid-job reset sequence.
module tb_ipf_feeder;
  import ipf_pkg::*;

  localparam int AW = 16, DW = 64, PW = 8, MAXL = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_w_base = '0, cfg_i_base = '0;
  logic [PW-1:0] cfg_npass = '0;
  logic          sink_ready = 1'b1;
  logic          busy, done, err;

  always #5 clk = ~clk;

  ipf_feeder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ipf_feeder #(.ADDR_W(AW), .DATA_W(DW), .ROWS(8), .RUN_CYC(32), .PASS_W(PW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_w_base(cfg_w_base),
    .cfg_i_base(cfg_i_base), .cfg_npass(cfg_npass), .sink_ready(sink_ready),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return {a, 16'hC3A5, ~a, a ^ 16'h5A5A};
  endfunction

  // SRAM: one cycle read latency
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem_f(bus.rd_addr);

  // IPF: one result beat per compute cycle (START held past its first cycle)
  logic [1:0] prev_ctrl = 2'd2;
  int drop_tok = 0, drop_used = 0;
  wire run_beat = (bus.ctrl == 2'd1) && (prev_ctrl == 2'd1);
  assign bus.res_valid = run_beat && (drop_tok == drop_used);
  always @(posedge clk) begin
    prev_ctrl <= bus.ctrl;
    if (run_beat && drop_tok != drop_used) drop_used <= drop_tok;
  end

  typedef struct {
    int npass; logic [AW-1:0] wb, ib; int dly; bit drop, ign;
    bit x_err; int x_nw, x_ni;
  } vec_t;

  logic [1:0]    e_ctrl[MAXL];
  bit            e_busy[MAXL], e_done[MAXL], e_err[MAXL], e_rd[MAXL];
  bit            e_wv[MAXL], e_iv[MAXL], e_sink[MAXL];
  logic [AW-1:0] e_addr[MAXL];
  logic [DW-1:0] e_wd[MAXL], e_id[MAXL];
  int            e_len, e_ign;
  bit            err_prev = 1'b0;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected cycle-by-cycle timeline; index 0 is the cycle cfg_start is high.
  task automatic build_model(input vec_t v);
    int o, s, nw, arm, st, err_at;
    logic [AW-1:0] wp, ip;
    for (int i = 0; i < MAXL; i++) begin
      e_ctrl[i] = 2'd2; e_busy[i] = 0; e_done[i] = 0; e_rd[i] = 0; e_addr[i] = '0;
      e_wv[i] = 0; e_iv[i] = 0; e_sink[i] = 1; e_wd[i] = '0; e_id[i] = '0;
    end
    e_ign = -1; err_at = MAXL; o = 1; wp = v.wb; ip = v.ib;
    for (int p = 0; p < v.npass; p++) begin
      nw = (p % 2) ? 4 : 5;
      s  = o;
      for (int k = 0; k < nw; k++) begin
        e_rd[s+k] = 1; e_addr[s+k] = wp; e_wv[s+2+k] = 1; e_wd[s+2+k] = mem_f(wp); wp++;
      end
      for (int k = 0; k < 8; k++) begin
        e_rd[s+nw+k] = 1; e_addr[s+nw+k] = ip; e_iv[s+nw+2+k] = 1; e_id[s+nw+2+k] = mem_f(ip); ip++;
      end
      arm = s + nw + 10;
      for (int d = 0; d < v.dly; d++) e_sink[arm+d] = 0;
      st = arm + v.dly + 1;
      for (int k = 0; k <= 32; k++) e_ctrl[st+k] = 2'd1;
      if (p == 0 && v.ign) e_ign = st + 5;
      if (p == 0 && v.drop) err_at = st + 34;
      o = st + 34;
    end
    e_ctrl[o] = 2'd0;
    e_done[o+1] = 1;
    for (int i = 1; i <= o + 1; i++) e_busy[i] = 1;
    e_len = o + 3;
    e_err[0] = err_prev;
    for (int i = 1; i < MAXL; i++) e_err[i] = (i >= err_at);
    err_prev = (err_at < MAXL);
  endtask

  task automatic run_job(input string tag, input vec_t v);
    int bad = 0, nwv = 0, niv = 0, ndone = 0;
    bit m;
    build_model(v);
    for (int o = 0; o < e_len; o++) begin
      @(negedge clk);
      m = (bus.ctrl !== e_ctrl[o]) || (busy !== e_busy[o]) || (done !== e_done[o]) ||
          (err !== e_err[o]) || (bus.rd_en !== e_rd[o]) ||
          (e_rd[o] && bus.rd_addr !== e_addr[o]) ||
          (bus.w_valid !== e_wv[o]) || (bus.i_valid !== e_iv[o]) ||
          (e_wv[o] && bus.w_data !== e_wd[o]) || (e_iv[o] && bus.i_data !== e_id[o]);
      if (m && bad == 0)
        $display("  %s first diff at cycle %0d: ctrl %0d/%0d busy %0b/%0b done %0b/%0b err %0b/%0b rd %0b/%0b wv %0b/%0b iv %0b/%0b",
                 tag, o, bus.ctrl, e_ctrl[o], busy, e_busy[o], done, e_done[o], err, e_err[o],
                 bus.rd_en, e_rd[o], bus.w_valid, e_wv[o], bus.i_valid, e_iv[o]);
      if (m) bad++;
      nwv += int'(bus.w_valid);
      niv += int'(bus.i_valid);
      ndone += int'(done);
      if (o == 0) begin
        cfg_start = 1'b1; cfg_npass = PW'(v.npass); cfg_w_base = v.wb; cfg_i_base = v.ib;
      end else if (o == e_ign) begin
        cfg_start = 1'b1; cfg_npass = 8'd3; cfg_w_base = 16'hDEAD; cfg_i_base = 16'hBEEF;
      end else cfg_start = 1'b0;
      sink_ready = e_sink[o];
    end
    check({tag, " trace cycles off"}, bad, 0);
    check({tag, " w words"}, nwv, v.x_nw);
    check({tag, " i words"}, niv, v.x_ni);
    check({tag, " done pulses"}, ndone, 1);
    check({tag, " err"}, err, v.x_err);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ctrl"}, bus.ctrl, 2);
    check({tag, " rd_en"}, bus.rd_en, 0);
    check({tag, " w_valid"}, bus.w_valid, 0);
    check({tag, " i_valid"}, bus.i_valid, 0);
    check({tag, " w_data"}, bus.w_data, 0);
    check({tag, " i_data"}, bus.i_data, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"}, err, 0);
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    tbl[0] = '{1, 16'h0100, 16'h0200, 0,  0, 0, 0, 5, 8};
    tbl[1] = '{2, 16'h0100, 16'h0200, 0,  0, 0, 0, 9, 16};
    tbl[2] = '{1, 16'h0100, 16'h0200, 20, 0, 0, 0, 5, 8};
    tbl[3] = '{1, 16'h0100, 16'h0200, 0,  1, 0, 1, 5, 8};
    tbl[4] = '{0, 16'h0100, 16'h0200, 0,  0, 0, 0, 0, 0};
    tbl[5] = '{2, 16'h0100, 16'h0200, 0,  0, 1, 0, 9, 16};
    tbl[6] = '{2, 16'hFFFE, 16'hFFFC, 3,  0, 0, 0, 9, 16};

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      if (tbl[t].drop) drop_tok++;
      run_job($sformatf("vec%0d", t), tbl[t]);
    end

    // Reset in the middle of the row load, then a clean job
    @(negedge clk);
    cfg_start = 1'b1; cfg_npass = 8'd1; cfg_w_base = 16'h0300; cfg_i_base = 16'h0400;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst rd_en before", bus.rd_en, 1);
    check("midrst rd_addr before", bus.rd_addr, 16'h0403);
    check("midrst busy before", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    err_prev = 1'b0;
    run_job("after_rst", '{1, 16'h0300, 16'h0400, 0, 0, 0, 0, 5, 8});

    for (int r = 0; r < 8; r++) begin
      rv.npass = $urandom_range(0, 3);
      rv.wb    = AW'($urandom);
      rv.ib    = AW'($urandom);
      rv.dly   = $urandom_range(0, 6);
      rv.drop  = (rv.npass > 0) && ($urandom_range(0, 1) == 1);
      rv.ign   = (rv.npass > 0) && ($urandom_range(0, 1) == 1);
      rv.x_err = rv.drop;
      rv.x_nw  = 0;
      for (int p = 0; p < rv.npass; p++) rv.x_nw += (p % 2) ? 4 : 5;
      rv.x_ni  = 8 * rv.npass;
      if (rv.drop) drop_tok++;
      run_job($sformatf("rnd%0d", r), rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
